// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline stage register with ready/valid
//                handshake, flush with channel retention, optional skid
//                buffer and a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int W       = 32,
    parameter int N_CH    = 5,
    parameter int SKID    = 0,
    parameter int KEEP_CH = 1,
    parameter int CW      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*W-1:0] out_data,
    input  logic              flush,
    output logic [CW-1:0]     stall_cnt,
    input  logic              clr_cnt
);

    localparam int         c_DW       = N_CH * W;
    // State encoding is {v_main, v_skid}; 2'b01 is unreachable.
    localparam logic [1:0] c_ST_EMPTY = 2'b00;
    localparam logic [1:0] c_ST_ONE   = 2'b10;
    localparam logic [1:0] c_ST_FULL  = 2'b11;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_v_main;
    logic            w_v_skid;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_issue;
    logic            w_ld_main_in;
    logic            w_ld_main_skid;
    logic            w_ld_skid;
    logic [c_DW-1:0] r_d_main;
    logic [c_DW-1:0] r_d_skid;
    logic [c_DW-1:0] w_flush_data;
    logic [CW-1:0]   r_stall_cnt;

    // Flush image: every channel cleared except the retained one.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        if (k == KEEP_CH) begin : g_keep
            assign w_flush_data[k*W +: W] = r_d_main[k*W +: W];
        end else begin : g_zero
            assign w_flush_data[k*W +: W] = '0;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = c_ST_EMPTY;
        end else if (SKID == 0) begin
            // Legacy behaviour: data is captured whenever the stage is open.
            if (w_in_ready) begin
                w_ld_main_in = 1'b1;
                w_state_nxt  = in_valid ? c_ST_ONE : c_ST_EMPTY;
            end
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && w_issue) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = c_ST_FULL;
                    end else if (w_issue) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    if (w_issue) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = c_ST_ONE;
                    end
                end
                default: w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_v_main = r_state[1];
        w_v_skid = r_state[0];
        if (SKID != 0) begin
            w_in_ready = ~w_v_skid;
        end else begin
            w_in_ready = out_ready | ~w_v_main;
        end
    end

    assign w_accept = in_valid & w_in_ready;
    assign w_issue  = w_v_main & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_main <= '0;
            r_d_skid <= '0;
        end else if (flush) begin
            r_d_main <= w_flush_data;
            r_d_skid <= w_flush_data;
        end else begin
            if (w_ld_main_in) begin
                r_d_main <= in_data;
            end else if (w_ld_main_skid) begin
                r_d_main <= r_d_skid;
            end
            if (w_ld_skid) begin
                r_d_skid <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !w_in_ready && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_v_main;
    assign out_data  = r_d_main;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg (SKID=0 and SKID=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int c_W  = 32;
    localparam int c_N  = 5;
    localparam int c_DW = c_W * c_N;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic            flush = 1'b0;
    logic            clr_cnt = 1'b0;
    logic [c_DW-1:0] in_data = '0;

    logic            s0_in_ready, s0_out_valid, s1_in_ready, s1_out_valid;
    logic [c_DW-1:0] s0_out_data, s1_out_data;
    logic [3:0]      s0_stall;
    logic [15:0]     s1_stall;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.W(c_W), .N_CH(c_N), .SKID(0), .KEEP_CH(1), .CW(4)) u_s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_data(in_data), .out_valid(s0_out_valid), .out_ready(out_ready),
        .out_data(s0_out_data), .flush(flush), .stall_cnt(s0_stall), .clr_cnt(clr_cnt)
    );

    pipe_stage_reg #(.W(c_W), .N_CH(c_N), .SKID(1), .KEEP_CH(1), .CW(16)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_data(in_data), .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_data(s1_out_data), .flush(flush), .stall_cnt(s1_stall), .clr_cnt(clr_cnt)
    );

    // Reference model: a one-slot stage and a two-deep FIFO.
    bit              m0_v;
    logic [c_DW-1:0] m0_d;
    int              m0_cnt;
    logic [c_DW-1:0] m1_q[$];
    logic [c_DW-1:0] m1_hold;
    int              m1_cnt;

    // Monitor of the SKID=1 instance for the fill/drain sequence.
    bit              mon_en = 1'b0;
    int              mon_acc = 0;
    logic [c_DW-1:0] mon_iss[$];

    function automatic logic [c_DW-1:0] mk(input logic [31:0] c0, input logic [31:0] c1);
        logic [c_DW-1:0] r;
        r = '0;
        r[31:0]  = c0;
        r[63:32] = c1;
        return r;
    endfunction

    function automatic logic [c_DW-1:0] keep_only(input logic [c_DW-1:0] d);
        logic [c_DW-1:0] r;
        r = '0;
        r[63:32] = d[63:32];
        return r;
    endfunction

    function automatic logic [c_DW-1:0] m1_out();
        return (m1_q.size() > 0) ? m1_q[0] : m1_hold;
    endfunction

    task automatic chk(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m0_v = 1'b0; m0_d = '0; m0_cnt = 0;
        m1_q.delete(); m1_hold = '0; m1_cnt = 0;
    endtask

    task automatic model_step();
        bit r0, r1;
        r0 = out_ready || !m0_v;
        r1 = m1_q.size() < 2;
        if (clr_cnt) m0_cnt = 0;
        else if (in_valid && !r0 && m0_cnt < 15) m0_cnt++;
        if (clr_cnt) m1_cnt = 0;
        else if (in_valid && !r1 && m1_cnt < 65535) m1_cnt++;
        if (flush) begin
            m0_v = 1'b0;
            m0_d = keep_only(m0_d);
            m1_hold = keep_only(m1_out());
            m1_q.delete();
        end else begin
            if (r0) begin
                m0_v = in_valid;
                m0_d = in_data;
            end
            if (m1_q.size() > 0 && out_ready) m1_hold = m1_q.pop_front();
            if (in_valid && r1) m1_q.push_back(in_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("s0_valid", c_DW'(s0_out_valid), c_DW'(m0_v));
            chk("s0_data", s0_out_data, m0_d);
            chk("s0_ready", c_DW'(s0_in_ready), c_DW'(out_ready || !m0_v));
            chk("s0_cnt", c_DW'(s0_stall), c_DW'(m0_cnt));
            chk("s1_valid", c_DW'(s1_out_valid), c_DW'(m1_q.size() > 0));
            chk("s1_data", s1_out_data, m1_out());
            chk("s1_ready", c_DW'(s1_in_ready), c_DW'(m1_q.size() < 2));
            chk("s1_cnt", c_DW'(s1_stall), c_DW'(m1_cnt));
            if (!s1_out_valid) chk("s1_no_state01", c_DW'(s1_in_ready), c_DW'(1));
            if (mon_en) begin
                if (in_valid && s1_in_ready) mon_acc++;
                if (s1_out_valid && out_ready) mon_iss.push_back(s1_out_data);
            end
        end
    end

    initial begin : main
        logic [c_DW-1:0] a, b, c, d, m;
        model_reset();

        // Reset state
        tick(); tick();
        chk("rst_s0_valid", c_DW'(s0_out_valid), '0);
        chk("rst_s0_data", s0_out_data, '0);
        chk("rst_s0_ready", c_DW'(s0_in_ready), c_DW'(1));
        chk("rst_s1_ready", c_DW'(s1_in_ready), c_DW'(1));
        chk("rst_s1_cnt", c_DW'(s1_stall), '0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Pass-through
        a = mk(32'h2408_0005, 32'h0000_3000);
        in_valid = 1'b1; out_ready = 1'b1; in_data = a;
        tick();
        chk("pt_valid", c_DW'(s0_out_valid), c_DW'(1));
        chk("pt_data", s0_out_data, a);
        chk("pt_cnt", c_DW'(s0_stall), '0);
        in_valid = 1'b0;
        tick();

        // SKID=0 stall
        a = mk(32'hAAAA_0001, 32'h0000_1000);
        b = mk(32'hBBBB_0002, 32'h0000_1004);
        in_valid = 1'b1; out_ready = 1'b1; in_data = a;
        tick();
        out_ready = 1'b0; in_data = b;
        repeat (3) tick();
        chk("st_hold", s0_out_data, a);
        chk("st_ready", c_DW'(s0_in_ready), '0);
        chk("st_cnt", c_DW'(s0_stall), c_DW'(3));
        out_ready = 1'b1;
        tick();
        chk("st_release", s0_out_data, b);
        in_valid = 1'b0; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;

        // SKID=1 fill/drain
        c = mk(32'hCCCC_0003, 32'h0000_1008);
        mon_en = 1'b1; mon_acc = 0; mon_iss.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        tick();
        in_data = b;
        tick();
        chk("fd_full_ready", c_DW'(s1_in_ready), '0);
        in_data = c;
        tick(); tick();
        chk("fd_cnt", c_DW'(s1_stall), c_DW'(2));
        out_ready = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        tick();
        mon_en = 1'b0;
        chk("fd_accepts", c_DW'(mon_acc), c_DW'(3));
        chk("fd_issues", c_DW'(mon_iss.size()), c_DW'(3));
        if (mon_iss.size() == 3) begin
            chk("fd_iss0", mon_iss[0], a);
            chk("fd_iss1", mon_iss[1], b);
            chk("fd_iss2", mon_iss[2], c);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;

        // Flush with channel 1 retained
        m = mk(32'h8C09_0004, 32'h0000_300C);
        out_ready = 1'b0; in_valid = 1'b1; in_data = m;
        tick();
        flush = 1'b1; in_data = mk(32'h1111_1111, 32'h0000_3010);
        tick();
        chk("fl_s0_valid", c_DW'(s0_out_valid), '0);
        chk("fl_s0_data", s0_out_data, mk(32'h0, 32'h0000_300C));
        chk("fl_s1_data", s1_out_data, mk(32'h0, 32'h0000_300C));
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_s0_ready", c_DW'(s0_in_ready), c_DW'(1));
        tick();
        chk("fl_discard", c_DW'(s1_out_valid), '0);

        // Flush while FULL
        d = mk(32'hDDDD_0004, 32'h0000_100C);
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        tick();
        in_data = b;
        tick();
        flush = 1'b1; in_data = c;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("ff_valid", c_DW'(s1_out_valid), '0);
        chk("ff_ready", c_DW'(s1_in_ready), c_DW'(1));
        in_valid = 1'b1; out_ready = 1'b1; in_data = d;
        tick();
        chk("ff_d_valid", c_DW'(s1_out_valid), c_DW'(1));
        chk("ff_d_data", s1_out_data, d);
        in_valid = 1'b0;
        tick();
        chk("ff_d_alone", c_DW'(s1_out_valid), '0);

        // Counter saturation and clear
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        repeat (21) tick();
        chk("sat_s0", c_DW'(s0_stall), c_DW'(15));
        chk("sat_s1", c_DW'(s1_stall), c_DW'(19));
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_s0", c_DW'(s0_stall), '0);
        chk("clr_s1", c_DW'(s1_stall), '0);

        // Asynchronous reset between edges
        tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("ar_s0_valid", c_DW'(s0_out_valid), '0);
        chk("ar_s0_cnt", c_DW'(s0_stall), '0);
        chk("ar_s1_valid", c_DW'(s1_out_valid), '0);
        chk("ar_s1_cnt", c_DW'(s1_stall), '0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            clr_cnt   = ($urandom_range(0, 29) == 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
        end
        flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
